mem_responder: RTL



---
 rtl/mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-RAM responder for split inst/data ports; serialises same-edge requests behind MEM_WAIT.
// Define MEM_RESPONDER_DUAL_PORT_EN to serve instruction reads from a second RAM port in parallel.
module mem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT
);
  typedef enum logic {IDLE, DRAIN} state_e;
  state_e      state_q, state_d;
  logic        pend_dr_q, pend_dr_d, pend_ir_q, pend_ir_d;
  logic [31:0] dr_addr_q, ir_addr_q, dr_addr, ir_addr;
  logic        acc, do_w, do_dr, do_ir;
  logic        d_rvalid_q, i_rvalid_q;
  logic [31:0] d_roaddr_q, i_roaddr_q, d_rdata_q, i_rdata_q;
  logic [31:0] ram [1 << DEPTH_LOG2];

  function automatic logic hit(input logic [31:0] a);
    return (({1'b0, a} - {1'b0, BASE_ADDR}) >> (DEPTH_LOG2 + 2)) == 33'd0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  // A write always executes at its accept edge, so only reads ever wait.
  always_comb begin
    acc     = state_q == IDLE;
    dr_addr = acc ? DATA_RIADDR : dr_addr_q;
    ir_addr = acc ? INST_RIADDR : ir_addr_q;
    do_w    = acc & DATA_WREN;
    do_dr   = acc ? DATA_RDEN & ~DATA_WREN : pend_dr_q;
    pend_dr_d = acc & DATA_RDEN & DATA_WREN;
`ifdef MEM_RESPONDER_DUAL_PORT_EN
    do_ir     = acc & INST_RDEN;
    pend_ir_d = 1'b0;
`else
    do_ir     = acc ? INST_RDEN & ~DATA_WREN & ~DATA_RDEN : pend_ir_q & ~pend_dr_q;
    pend_ir_d = acc ? INST_RDEN & (DATA_WREN | DATA_RDEN) : pend_ir_q & pend_dr_q;
`endif
    state_d = (pend_dr_d | pend_ir_d) ? DRAIN : IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pend_dr_q  <= 1'b0;
      pend_ir_q  <= 1'b0;
      dr_addr_q  <= '0;
      ir_addr_q  <= '0;
      d_rvalid_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_roaddr_q <= '0;
      i_roaddr_q <= '0;
      d_rdata_q  <= '0;
      i_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_dr_q  <= pend_dr_d;
      pend_ir_q  <= pend_ir_d;
      d_rvalid_q <= do_dr;
      i_rvalid_q <= do_ir;
      if (acc) begin
        dr_addr_q <= DATA_RIADDR;
        ir_addr_q <= INST_RIADDR;
      end
      if (do_dr) begin
        d_roaddr_q <= dr_addr;
        d_rdata_q  <= hit(dr_addr) ? ram[idx(dr_addr)] : '0;
      end
      if (do_ir) begin
        i_roaddr_q <= ir_addr;
        i_rdata_q  <= hit(ir_addr) ? ram[idx(ir_addr)] : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_w && !RST && hit(DATA_WADDR))
      for (int n = 0; n < 4; n++)
        if (DATA_WSTRB[n]) ram[idx(DATA_WADDR)][8*n +: 8] <= DATA_WDATA[8*n +: 8];
  end

  assign MEM_WAIT    = pend_dr_q | pend_ir_q;
  assign DATA_RVALID = d_rvalid_q;
  assign DATA_ROADDR = d_roaddr_q;
  assign DATA_RDATA  = d_rdata_q;
  assign INST_RVALID = i_rvalid_q;
  assign INST_ROADDR = i_roaddr_q;
  assign INST_RDATA  = i_rdata_q;
endmodule
